// File: rtl/gcd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gcd_ctrl_pkg
//   Shared definitions for the GCD CPU host-side run sequencer:
//   - 3-bit FSM state encoding (IDLE..DONE)
//   - default data-memory map for operand A, operand B and the result word
//   - default run and start-acknowledge timeouts
//   - saturating 32-bit increment used by the optional run-cycle counter
// -----------------------------------------------------------------------------
package gcd_ctrl_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_LOAD_A   = 3'd1;
  localparam state_t S_LOAD_B   = 3'd2;
  localparam state_t S_START    = 3'd3;
  localparam state_t S_WAIT_BSY = 3'd4;
  localparam state_t S_RUN      = 3'd5;
  localparam state_t S_READ     = 3'd6;
  localparam state_t S_DONE     = 3'd7;

  localparam int DEF_ADDR_A     = 0;
  localparam int DEF_ADDR_B     = 1;
  localparam int DEF_ADDR_RES   = 2;
  localparam int DEF_START_WAIT = 4;
  localparam int DEF_TIMEOUT    = 10000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gcd_run_timer.sv
// -----------------------------------------------------------------------------
// gcd_run_timer
//   Loadable down-counter that stops at zero (never wraps). o_zero flags the
//   terminal count. Load has priority over decrement.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset (count -> 0)
//   i_load     in  load i_load_val this cycle
//   i_load_val in  value to load [W-1:0]
//   i_dec      in  decrement by one if not already zero
//   o_zero     out count == 0
// -----------------------------------------------------------------------------
module gcd_run_timer #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Counter register: load, saturating decrement, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != {W{1'b0}})) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/gcd_run_ctrl.sv
// -----------------------------------------------------------------------------
// gcd_run_ctrl
//   Host-side run sequencer for the GCD CPU. Takes one operand pair per
//   request, writes both into CPU data memory, pulses start, waits for bsy to
//   rise and fall, reads the result word back and returns it (or a timeout
//   flag) over a valid/ready handshake. A zero operand short-circuits the CPU:
//   gcd(x,0) = x, returned the cycle after accept.
//
// Optional feature macro: GCD_RUN_CYCLE_COUNT_EN
//   Defined  : adds output run_cycles[31:0], cycles spent from START up to
//              DONE, saturating, valid and held with res_valid.
//   Undefined: no run_cycles port and no counter.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   op_a, op_b               operands, sampled on accept
//   cpu_wen/haddr/hdin       host write port into CPU data memory
//   cpu_start                one-cycle run pulse
//   cpu_bsy, cpu_dout        CPU busy and host read data
//   res_valid/res_ready      result handshake
//   res_data, res_timeout    result word (0 on timeout) and abort flag
//   busy                     controller not idle
// -----------------------------------------------------------------------------
module gcd_run_ctrl
  import gcd_ctrl_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int ADDR_A     = DEF_ADDR_A,
  parameter int ADDR_B     = DEF_ADDR_B,
  parameter int ADDR_RES   = DEF_ADDR_RES,
  parameter int START_WAIT = DEF_START_WAIT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int READ_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          cpu_wen,
  output logic [AW-1:0] cpu_haddr,
  output logic [DW-1:0] cpu_hdin,
  output logic          cpu_start,
  input  logic          cpu_bsy,
  input  logic [DW-1:0] cpu_dout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_timeout,
  output logic          busy
`ifdef GCD_RUN_CYCLE_COUNT_EN
  ,
  output logic [31:0]   run_cycles
`endif
);

  // One timer covers both windows, so it is sized for the larger of the two.
  localparam int TMAX = (TIMEOUT > START_WAIT) ? TIMEOUT : START_WAIT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RLW  = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_op_a;
  logic [DW-1:0]   r_op_b;
  logic            r_req_ready;
  logic [DW-1:0]   r_res_data;
  logic            r_res_timeout;
  logic [AW-1:0]   r_haddr_hold;
  logic [DW-1:0]   r_hdin_hold;
  logic [RLW-1:0]  r_rd_cnt;
  logic [AW-1:0]   w_haddr;
  logic [DW-1:0]   w_hdin;
  logic            w_accept;
  logic            w_zero_op;
  logic            w_rd_done;
  logic            w_tmr_load;
  logic [TW-1:0]   w_tmr_val;
  logic            w_tmr_dec;
  logic            w_tmr_zero;

  assign w_accept  = req_valid & r_req_ready;
  assign w_zero_op = (op_a == {DW{1'b0}}) | (op_b == {DW{1'b0}});
  assign w_rd_done = (r_rd_cnt == RLW'(READ_LAT));

  gcd_run_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_zero_op ? S_DONE : S_LOAD_A;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_START;
      S_START:  w_next = S_WAIT_BSY;
      S_WAIT_BSY: begin
        if (cpu_bsy) begin
          w_next = S_RUN;
        end else if (w_tmr_zero) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WAIT_BSY;
        end
      end
      S_RUN: begin
        if (!cpu_bsy) begin
          w_next = S_READ;
        end else if (w_tmr_zero) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_READ: begin
        if (w_rd_done) begin
          w_next = S_DONE;
        end else begin
          w_next = S_READ;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Timer control. The WAIT_BSY window is START_WAIT cycles with bsy low.
  // For RUN, the WAIT_BSY cycle that first sees bsy counts as busy cycle 1,
  // so RUN aborts after TIMEOUT-1 further busy cycles: DONE lands exactly
  // TIMEOUT cycles after bsy rose.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = {TW{1'b0}};
    w_tmr_dec  = 1'b0;
    case (r_state)
      S_START: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TW'(START_WAIT - 1);
      end
      S_WAIT_BSY: begin
        if (cpu_bsy) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(TIMEOUT - 2);
        end else begin
          w_tmr_dec  = 1'b1;
        end
      end
      S_RUN:   w_tmr_dec = 1'b1;
      default: w_tmr_dec = 1'b0;
    endcase
  end

  // FSM outputs: strobes decoded from the state register, host port muxed
  // from operand registers; haddr/hdin otherwise hold their last value.
  always_comb begin
    cpu_wen   = 1'b0;
    cpu_start = 1'b0;
    res_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    w_haddr   = r_haddr_hold;
    w_hdin    = r_hdin_hold;
    case (r_state)
      S_LOAD_A: begin
        cpu_wen = 1'b1;
        w_haddr = AW'(ADDR_A);
        w_hdin  = r_op_a;
      end
      S_LOAD_B: begin
        cpu_wen = 1'b1;
        w_haddr = AW'(ADDR_B);
        w_hdin  = r_op_b;
      end
      S_START: cpu_start = 1'b1;
      S_READ:  w_haddr   = AW'(ADDR_RES);
      S_DONE:  res_valid = 1'b1;
      default: cpu_wen   = 1'b0;
    endcase
  end

  assign cpu_haddr   = w_haddr;
  assign cpu_hdin    = w_hdin;
  assign req_ready   = r_req_ready;
  assign res_data    = r_res_data;
  assign res_timeout = r_res_timeout;

  // Operand capture on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a <= {DW{1'b0}};
      r_op_b <= {DW{1'b0}};
    end else if (w_accept) begin
      r_op_a <= op_a;
      r_op_b <= op_b;
    end else begin
      r_op_a <= r_op_a;
      r_op_b <= r_op_b;
    end
  end

  // Host-port hold registers, request-ready and read-latency counter.
  // req_ready is registered so it stays low while rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_haddr_hold <= {AW{1'b0}};
      r_hdin_hold  <= {DW{1'b0}};
      r_req_ready  <= 1'b0;
      r_rd_cnt     <= {RLW{1'b0}};
    end else begin
      r_haddr_hold <= w_haddr;
      r_hdin_hold  <= w_hdin;
      r_req_ready  <= (w_next == S_IDLE);
      if ((r_state == S_READ) && !w_rd_done) begin
        r_rd_cnt <= r_rd_cnt + {{(RLW-1){1'b0}}, 1'b1};
      end else if (r_state != S_READ) begin
        r_rd_cnt <= {RLW{1'b0}};
      end else begin
        r_rd_cnt <= r_rd_cnt;
      end
    end
  end

  // Result registers: loaded on the way into DONE, cleared on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_data    <= {DW{1'b0}};
      r_res_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next == S_DONE) begin
            r_res_data    <= op_a | op_b;
            r_res_timeout <= 1'b0;
          end else begin
            r_res_data    <= r_res_data;
            r_res_timeout <= r_res_timeout;
          end
        end
        S_WAIT_BSY, S_RUN: begin
          if (w_next == S_DONE) begin
            r_res_data    <= {DW{1'b0}};
            r_res_timeout <= 1'b1;
          end else begin
            r_res_data    <= r_res_data;
            r_res_timeout <= r_res_timeout;
          end
        end
        S_READ: begin
          if (w_next == S_DONE) begin
            r_res_data    <= cpu_dout;
            r_res_timeout <= 1'b0;
          end else begin
            r_res_data    <= r_res_data;
            r_res_timeout <= r_res_timeout;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_data    <= {DW{1'b0}};
            r_res_timeout <= 1'b0;
          end else begin
            r_res_data    <= r_res_data;
            r_res_timeout <= r_res_timeout;
          end
        end
        default: begin
          r_res_data    <= r_res_data;
          r_res_timeout <= r_res_timeout;
        end
      endcase
    end
  end

`ifdef GCD_RUN_CYCLE_COUNT_EN
  logic [31:0] r_run_cycles;

  // Run-cycle counter: cleared on accept and handshake, counts START..READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cycles <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_run_cycles <= 32'd0;
          end else begin
            r_run_cycles <= r_run_cycles;
          end
        end
        S_START, S_WAIT_BSY, S_RUN, S_READ: r_run_cycles <= sat_inc32(r_run_cycles);
        S_DONE: begin
          if (res_ready) begin
            r_run_cycles <= 32'd0;
          end else begin
            r_run_cycles <= r_run_cycles;
          end
        end
        default: r_run_cycles <= r_run_cycles;
      endcase
    end
  end

  assign run_cycles = r_run_cycles;
`endif

endmodule
